// File: rtl/pll_lock_sequencer.sv
// Sequences the GMII 125 MHz PLL: areset pulse, stable-lock qualification, TX reset release,
// retry/fault handling. Define PLL_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_lock_sequencer #(
  parameter int ARESET_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_areset,
  output logic       rst_out,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt
`ifdef PLL_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int AW = (ARESET_CYCLES > 1)       ? $clog2(ARESET_CYCLES)       : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES)  : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam logic [AW-1:0] AREA_LAST = AW'(ARESET_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic [AW-1:0] area_cnt, area_nxt;
  logic [SW-1:0] stb_cnt, stb_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [7:0]    retry_nxt;
  logic          timeout;

  assign locked_s = sync_q[1];
  assign timeout  = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], pll_locked};
  end

  always_comb begin
    state_nxt = state;
    area_nxt  = '0;
    stb_nxt   = '0;
    tmo_nxt   = '0;
    retry_nxt = retry_cnt;
    case (state)
      RESET_PLL: begin
        if (area_cnt == AREA_LAST) state_nxt = WAIT_LOCK;
        else                       area_nxt  = area_cnt + AW'(1);
      end
      WAIT_LOCK, STABLE: begin
        // tmo_cnt spans both states so a glitching lock cannot extend the attempt
        tmo_nxt = tmo_cnt + TW'(1);
        if (timeout) begin
          tmo_nxt = '0;
          if (retry_cnt == RETRY_MAX) state_nxt = FAULT;
          else begin
            retry_nxt = retry_cnt + 8'd1;
            state_nxt = RESET_PLL;
          end
        end else if (state == WAIT_LOCK) begin
          if (locked_s) state_nxt = STABLE;
        end else if (!locked_s) begin
          state_nxt = WAIT_LOCK;
        end else if (stb_cnt == STB_LAST) begin
          state_nxt = RUN;
        end else begin
          stb_nxt = stb_cnt + SW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = RESET_PLL;
          retry_nxt = '0;
        end
      end
      FAULT: ;
      default: state_nxt = RESET_PLL;
    endcase
    if (restart) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
      area_nxt  = '0;
      stb_nxt   = '0;
      tmo_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_PLL;
      area_cnt   <= '0;
      stb_cnt    <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      pll_areset <= 1'b1;
      rst_out    <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      area_cnt   <= area_nxt;
      stb_cnt    <= stb_nxt;
      tmo_cnt    <= tmo_nxt;
      retry_cnt  <= retry_nxt;
      pll_areset <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
      rst_out    <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
      fault      <= (state_nxt == FAULT);
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  // a lock loss coinciding with restart still counts
  logic loss_evt;
  assign loss_evt = (state == RUN) && !locked_s;

  always_ff @(posedge clk) begin
    if (reset)                              loss_cnt <= '0;
    else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output changes (value + edge number) are
// queued as stimulus is driven and popped whenever the DUT outputs change.
module tb_pll_lock_sequencer;
  localparam int A = 4, S = 8, T = 32, R = 2;

  logic       clk = 1'b0;
  logic       reset, pll_locked, restart;
  logic       pll_areset, rst_out, ready, fault;
  logic [7:0] retry_cnt;
  logic [7:0] loss_w;
  logic [19:0] outs, prev;
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;
  int         exp_loss = 0;
  logic       mon_en = 1'b0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [19:0] val;
  } exp_t;
  exp_t sb[$];

  pll_lock_sequencer #(
    .ARESET_CYCLES(A), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(R)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .restart(restart),
    .pll_areset(pll_areset), .rst_out(rst_out), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt)
`ifdef PLL_LOSS_COUNT_EN
    , .loss_cnt(loss_w)
`endif
  );

`ifndef PLL_LOSS_COUNT_EN
  assign loss_w = 8'd0;
`endif

  assign outs = {pll_areset, rst_out, ready, fault, retry_cnt, loss_w};

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [19:0] vec(input logic a, input logic r, input logic rd,
                                      input logic f, input int rc);
`ifdef PLL_LOSS_COUNT_EN
    return {a, r, rd, f, 8'(rc), 8'(exp_loss)};
`else
    return {a, r, rd, f, 8'(rc), 8'd0};
`endif
  endfunction

  task automatic push(input string tag, input int c, input logic [19:0] v);
    exp_t e;
    e.tag = tag; e.cyc = c; e.val = v;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // every output change must match the head of the scoreboard, at the predicted edge
  always @(negedge clk) begin
    if (mon_en && outs !== prev) begin
      if (sb.size() == 0) chk("unexpected_change", 32'(outs), 32'(prev));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_edge"}, cyc, e.cyc);
        chk(e.tag, 32'(outs), 32'(e.val));
      end
    end
    prev = outs;
  end

  initial begin
    int k, f, c;
    reset = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    @(negedge clk);
    wait_to(3);
    chk("rst_areset", 32'(pll_areset), 1);
    chk("rst_rst_out", 32'(rst_out), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_loss", 32'(loss_w), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // power-up: areset held A cycles, lock 5 cycles later, release S+3 edges after lock (1-based)
    f = cyc + A;
    push("pwr_areset_fall", f, vec(0, 1, 0, 0, 0));
    wait_to(f + 5);
    pll_locked = 1'b1; k = cyc + 1;
    push("pwr_run", k + S + 2, vec(0, 0, 1, 0, 0));
    wait_to(k + S + 8);

    // lock drop in RUN, then a 1-cycle glitch mid-STABLE
    c = cyc;
    pll_locked = 1'b0; exp_loss++;
    push("loss", c + 3, vec(1, 1, 0, 0, 0));
    f = c + 3 + A;
    push("loss_areset_fall", f, vec(0, 1, 0, 0, 0));
    wait_to(f + 1);
    pll_locked = 1'b1; k = cyc + 1;
    wait_to(k + 5);
    pll_locked = 1'b0;
    wait_to(k + 6);
    pll_locked = 1'b1;
    push("glitch_run", (k + 7) + S + 2, vec(0, 0, 1, 0, 0));
    wait_to(k + S + 14);

    // lock drop coinciding with restart; then no lock -> retries -> FAULT
    c = cyc;
    pll_locked = 1'b0; exp_loss++;
    push("loss_restart", c + 3, vec(1, 1, 0, 0, 0));
    f = c + 3 + A;
    push("lr_areset_fall", f, vec(0, 1, 0, 0, 0));
    for (int r = 1; r <= R; r++) begin
      push($sformatf("retry%0d", r), f + T, vec(1, 1, 0, 0, r));
      f = f + T + A;
      push($sformatf("retry%0d_fall", r), f, vec(0, 1, 0, 0, r));
    end
    push("fault", f + T, vec(1, 1, 0, 1, R));
    wait_to(c + 2);
    restart = 1'b1;
    wait_to(c + 3);
    restart = 1'b0;
    wait_to(f + T + 5);

    // restart from FAULT
    c = cyc;
    restart = 1'b1;
    push("restart_fault", c + 1, vec(1, 1, 0, 0, 0));
    f = c + 1 + A;
    push("restart_areset_fall", f, vec(0, 1, 0, 0, 0));
    wait_to(c + 1);
    restart = 1'b0;
    wait_to(f + 3);
    pll_locked = 1'b1; k = cyc + 1;
    push("restart_run", k + S + 2, vec(0, 0, 1, 0, 0));
    wait_to(k + S + 6);

    // reset during RUN; lock already present while in RESET_PLL is ignored until WAIT_LOCK
    c = cyc;
    reset = 1'b1; exp_loss = 0;
    push("reset_in_run", c + 1, vec(1, 1, 0, 0, 0));
    wait_to(c + 2);
    reset = 1'b0;
    f = c + 2 + A;
    push("post_reset_fall", f, vec(0, 1, 0, 0, 0));
    push("post_reset_run", f + 1 + S, vec(0, 0, 1, 0, 0));
    wait_to(f + S + 10);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
